pio_sm_core: RTL and testbench

Parametrised PIO state-machine core: instruction memory with a program-load port, a program counter with configurable wrap, an optional integer clock divider, and a valid/ready issue port. It fetches, resolves unconditional jumps internally, and hands every other instruction to a downstream executor that may stall. It supersedes the fixed 32×16 core; one instance per PIO state machine.

---
 rtl/pio_sm_core_if.sv | 11 +
 rtl/pio_sm_core.sv | 146 ++++++++++++++
 tb/tb_pio_sm_core.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_sm_core_if.sv
// rtl/pio_sm_core_if.sv - issue handshake between a PIO state machine and its executor
interface pio_sm_core_if #(
  parameter int INSTR_W = 16
);
  logic               issue_valid;
  logic [INSTR_W-1:0] issue_instr;
  logic               issue_ready;

  modport master (output issue_valid, output issue_instr, input issue_ready);
  modport slave  (input issue_valid, input issue_instr, output issue_ready);
endinterface

// File: rtl/pio_sm_core.sv
// rtl/pio_sm_core.sv - PIO state-machine core: program memory, wrapping PC, divider, issue port
// Optional divider built when PIO_SM_CLKDIV_EN is defined; otherwise every enabled cycle ticks.
module pio_sm_core #(
  parameter  int DEPTH   = 32,
  parameter  int INSTR_W = 16,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               restart,
  input  logic [15:0]        clkdiv_int,
  input  logic [ADDR_W-1:0]  wrap_bottom,
  input  logic [ADDR_W-1:0]  wrap_top,
  input  logic               prog_wr_en,
  input  logic [ADDR_W-1:0]  prog_wr_addr,
  input  logic [INSTR_W-1:0] prog_wr_data,
  pio_sm_core_if.master      issue,
  output logic [ADDR_W-1:0]  pc
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               tick;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] fetch;
  logic               is_jmp;
  logic [ADDR_W-1:0]  jmp_target;
  logic [ADDR_W-1:0]  pc_adv;

  assign fetch      = mem[pc];
  assign is_jmp     = (fetch[INSTR_W-1:INSTR_W-3] == 3'b000);
  assign jmp_target = fetch[ADDR_W-1:0];
  // Wrap is checked only when advancing, so a JMP beyond wrap_top is honoured.
  assign pc_adv     = (pc == wrap_top) ? wrap_bottom : pc + ADDR_W'(1);

  assign issue.issue_valid = valid_q;
  assign issue.issue_instr = instr_q;

  // Program memory: unreset storage, write visible to fetch from the next cycle.
  always_ff @(posedge clk) begin
    if (prog_wr_en) begin
      mem[prog_wr_addr] <= prog_wr_data;
    end
  end

`ifdef PIO_SM_CLKDIV_EN
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [15:0] div_last;

  // A ratio of 0 behaves as 1, so the last count is then 0.
  assign div_last = (clkdiv_int == 16'd0) ? 16'd0 : clkdiv_int - 16'd1;
  assign tick     = en && (div_cnt_q == div_last);

  // Divider next count: held at 0 when disabled, wraps early if the ratio shrank below it.
  always_comb begin
    div_cnt_d = div_cnt_q + 16'd1;
    if (restart || !en || (div_cnt_q >= div_last)) begin
      div_cnt_d = 16'd0;
    end
  end

  // Divider count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= 16'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end
`else
  logic unused_clkdiv;

  assign unused_clkdiv = ^clkdiv_int;
  assign tick          = en;
`endif

  // Next-state logic: restart wins over ticks and handshakes, and is the only way to withdraw an offer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    valid_d = valid_q;
    instr_d = instr_q;
    if (restart) begin
      pc_d    = '0;
      valid_d = 1'b0;
      state_d = en ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state_d = ST_IDLE;
          end else if (tick) begin
            if (is_jmp) begin
              pc_d = jmp_target;
            end else begin
              valid_d = 1'b1;
              instr_d = fetch;
              state_d = ST_STALL;
            end
          end
        end
        ST_STALL: begin
          if (valid_q && issue.issue_ready) begin
            pc_d    = pc_adv;
            valid_d = 1'b0;
            state_d = en ? ST_RUN : ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, PC and offer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc      <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_pio_sm_core.sv
// tb/tb_pio_sm_core.sv - scoreboard bench for pio_sm_core with a program-walk reference model
module tb_pio_sm_core;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  typedef struct {
    logic [15:0]   instr;
    logic [AW-1:0] pc;
    int            gap;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          restart = 1'b0;
  logic [15:0]   clkdiv_int = 16'd1;
  logic [AW-1:0] wrap_bottom = '0;
  logic [AW-1:0] wrap_top = '1;
  logic          prog_wr_en = 1'b0;
  logic [AW-1:0] prog_wr_addr = '0;
  logic [15:0]   prog_wr_data = '0;
  logic [AW-1:0] pc;
  logic          ready = 1'b0;

  pio_sm_core_if #(.INSTR_W(16)) ifc ();
  assign ifc.issue_ready = ready;

  pio_sm_core #(.DEPTH(DEPTH), .INSTR_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .restart      (restart),
    .clkdiv_int   (clkdiv_int),
    .wrap_bottom  (wrap_bottom),
    .wrap_top     (wrap_top),
    .prog_wr_en   (prog_wr_en),
    .prog_wr_addr (prog_wr_addr),
    .prog_wr_data (prog_wr_data),
    .issue        (ifc),
    .pc           (pc)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   n_pops = 0;
  int   cyc = 0;
  int   last_hs = -1;
  int   rdy_mode = 0;
  int   en_mode = 0;
  exp_t sb[$];
  logic [15:0] ref_mem [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] adv(input logic [AW-1:0] p);
    if (p == wrap_top) return wrap_bottom;
    return AW'((int'(p) + 1) % DEPTH);
  endfunction

  // Walk the program as an executor would see it; r is the tick ratio used for spacing.
  task automatic gen(input int n, input int r, input bit timed, output int produced);
    int            jumps = 0;
    bit            first = 1'b1;
    logic [AW-1:0] p = '0;
    logic [15:0]   ins;
    exp_t          e;
    produced = 0;
    while (produced < n && jumps <= DEPTH) begin
      ins = ref_mem[p];
      if (ins[15:13] == 3'b000) begin
        p = ins[AW-1:0];
        jumps++;
      end else begin
        e.instr = ins;
        e.pc    = p;
        e.gap   = (first || !timed) ? 0 : r * ((r + 1) / r) + jumps * r;
        sb.push_back(e);
        produced++;
        jumps = 0;
        first = 1'b0;
        p = adv(p);
      end
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      prog_wr_en   = 1'b1;
      prog_wr_addr = AW'(i);
      prog_wr_data = ref_mem[i];
    end
    @(posedge clk); #1;
    prog_wr_en = 1'b0;
  endtask

  task automatic load_one(input int a, input logic [15:0] d);
    ref_mem[a] = d;
    @(posedge clk); #1;
    prog_wr_en   = 1'b1;
    prog_wr_addr = AW'(a);
    prog_wr_data = d;
    @(posedge clk); #1;
    prog_wr_en = 1'b0;
  endtask

  task automatic wait_pops(input string name, input int target, input int budget);
    int k = 0;
    while (n_pops < target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_issue_count"}, n_pops, target);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k = 0;
    while (!ifc.issue_valid && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_offer_seen"}, 32'(ifc.issue_valid), 32'd1);
  endtask

  // Called at posedge+1: park the core in IDLE at pc 0 and discard leftover expectations.
  task automatic stop();
    en_mode  = 0;
    rdy_mode = 0;
    en       = 1'b0;
    ready    = 1'b0;
    restart  = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    sb.delete();
    last_hs = -1;
    n_pops  = 0;
  endtask

  task automatic fill_counting();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h2000 | 16'(i);
  endtask

  // Random-mode drivers for ready and en.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 2) ready = 1'($urandom_range(0, 1));
      if (en_mode == 2) en = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: checks each accepted issue against the scoreboard and offer stability under stall.
  logic          pv = 1'b0, pr = 1'b0, prs = 1'b0;
  logic [15:0]   pi = '0;
  logic [AW-1:0] ppc = '0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr && !prs) begin
        chk("offer_held", {15'd0, ifc.issue_valid, ifc.issue_instr}, {15'd0, 1'b1, pi});
        chk("pc_held_in_stall", 32'(pc), 32'(ppc));
      end
      if (ifc.issue_valid && ready && !restart) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_issue: got instr %h pc %0d expected none", ifc.issue_instr, pc);
        end else begin
          e = sb.pop_front();
          chk("issue_instr", 32'(ifc.issue_instr), 32'(e.instr));
          chk("issue_pc", 32'(pc), 32'(e.pc));
          if (e.gap != 0 && last_hs >= 0) chk("issue_spacing", cyc - last_hs, e.gap);
        end
        last_hs = cyc;
        n_pops++;
      end
      pv  = ifc.issue_valid;
      pr  = ready;
      prs = restart;
      pi  = ifc.issue_instr;
      ppc = pc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int produced;
    int r;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", 32'(pc), 0);
    chk("reset_valid", 32'(ifc.issue_valid), 0);
    chk("reset_instr", 32'(ifc.issue_instr), 0);
    rst = 1'b1;

    // Counting program wrapped over 0..3 at full rate
    fill_counting();
    load_prog();
    wrap_bottom = 0; wrap_top = 3; clkdiv_int = 1;
    gen(5, 1, 1'b1, produced);
    rdy_mode = 1; ready = 1'b1; en = 1'b1;
    wait_pops("wrap4", produced, 100);
    stop();

    // Asynchronous reset mid-run, program survives
    gen(20, 1, 1'b0, produced);
    rdy_mode = 1; ready = 1'b1; en = 1'b1;
    repeat (7) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_pc", 32'(pc), 0);
    chk("async_rst_valid", 32'(ifc.issue_valid), 0);
    chk("async_rst_instr", 32'(ifc.issue_instr), 0);
    sb.delete();
    en = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    last_hs = -1;
    n_pops = 0;
    @(posedge clk); #1;
    gen(4, 1, 1'b1, produced);
    en = 1'b1;
    wait_pops("after_rst", produced, 100);
    stop();

    // Unconditional jump is resolved internally
    fill_counting();
    ref_mem[0] = 16'h0005;
    ref_mem[5] = 16'h4000;
    load_prog();
    wrap_bottom = 0; wrap_top = 31;
    gen(2, 1, 1'b1, produced);
    rdy_mode = 1; ready = 1'b1; en = 1'b1;
    wait_pops("jmp", produced, 100);
    stop();

    // Divided tick rate over a 5-entry loop
    fill_counting();
    load_prog();
    wrap_bottom = 0; wrap_top = 4; clkdiv_int = 3;
`ifdef PIO_SM_CLKDIV_EN
    r = 3;
`else
    r = 1;
`endif
    gen(7, r, 1'b1, produced);
    rdy_mode = 1; ready = 1'b1; en = 1'b1;
    wait_pops("ratio", produced, 200);
    stop();
    clkdiv_int = 1;

    // Long stall with en pulsed low
    fill_counting();
    ref_mem[0] = 16'h6001;
    ref_mem[1] = 16'h2222;
    load_prog();
    wrap_bottom = 0; wrap_top = 31;
    gen(2, 1, 1'b0, produced);
    en = 1'b1;
    wait_valid("stall", 20);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) en = 1'b0;
      if (i == 5) en = 1'b1;
      #3;
      chk("stall_valid", 32'(ifc.issue_valid), 1);
      chk("stall_instr", 32'(ifc.issue_instr), 32'h6001);
      chk("stall_pc", 32'(pc), 0);
      @(posedge clk); #1;
    end
    rdy_mode = 1; ready = 1'b1;
    wait_pops("stall", produced, 100);
    stop();

    // Restart withdraws a pending offer at pc 7
    fill_counting();
    ref_mem[0] = 16'h0007;
    ref_mem[7] = 16'h6007;
    load_prog();
    en = 1'b1;
    wait_valid("restart", 20);
    chk("restart_stall_pc", 32'(pc), 7);
    load_one(0, 16'h3abc);
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    #2;
    chk("restart_valid", 32'(ifc.issue_valid), 0);
    chk("restart_pc", 32'(pc), 0);
    sb.delete();
    n_pops = 0;
    gen(3, 1, 1'b0, produced);
    rdy_mode = 1; ready = 1'b1;
    wait_pops("restart", produced, 100);
    stop();

    // Self-jump spins without issuing
    fill_counting();
    ref_mem[0] = 16'h0000;
    load_prog();
    gen(1, 1, 1'b0, produced);
    chk("spin_model_empty", 32'(produced), 0);
    rdy_mode = 1; ready = 1'b1; en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("spin_no_issue", 32'(n_pops), 0);
    chk("spin_pc", 32'(pc), 0);
    stop();

    // Randomized programs, wrap windows, ratios, ready and en
    for (int round = 0; round < 6; round++) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 3) == 0) w[15:13] = 3'b000;
        else if (w[15:13] == 3'b000) w[13] = 1'b1;
        ref_mem[i] = w;
      end
      load_prog();
      wrap_bottom = AW'($urandom_range(0, DEPTH - 1));
      wrap_top    = AW'($urandom_range(0, DEPTH - 1));
      clkdiv_int  = 16'($urandom_range(0, 4));
      gen(20, 1, 1'b0, produced);
      rdy_mode = 2; en_mode = 2;
      wait_pops("random", produced, 1500);
      if (produced < 20) repeat (30) @(posedge clk);
      #1;
      stop();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
